// File: rtl/if_program_loader.sv
// IF-stage program loader and step sequencer: packs UART bytes into IMEM words, then gates pipeline steps until HALT drains.
// Latency: IMEM write strobe one cycle after the 4th byte of a word; o_step is combinational from state and commands (zero latency).
// Backpressure: o_rx_ready drops during each write cycle and stays low once loading ends; later bytes are left unaccepted.
module if_program_loader #(
    parameter int                   BITS_SIZE  = 32,
    parameter int                   SIZE_TOTAL = 256,
    parameter logic [BITS_SIZE-1:0] HALT_INSTR = 32'hFFFFFFFF,
    parameter int                   PIPE_DRAIN = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [7:0]           i_rx_data,
    input  logic                 i_rx_valid,
    output logic                 o_rx_ready,
    input  logic                 i_cmd_run,
    input  logic                 i_cmd_step,
    input  logic [BITS_SIZE-1:0] i_fetch_instr,
    output logic [BITS_SIZE-1:0] o_instrucction_address,
    output logic [BITS_SIZE-1:0] o_instruction,
    output logic                 o_flag_write_intruc,
    output logic                 o_step,
    output logic                 o_load_done,
    output logic                 o_halted,
    output logic                 o_overflow,
    output logic [BITS_SIZE-1:0] o_step_count
);

    localparam int                   DW        = (PIPE_DRAIN < 1) ? 1 : $clog2(PIPE_DRAIN + 1);
    localparam logic [BITS_SIZE-1:0] LAST_ADDR = BITS_SIZE'(SIZE_TOTAL - 4);

    typedef enum logic [2:0] {
        S_LOAD,
        S_READY,
        S_RUN,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           byte_cnt_q, byte_cnt_d;
    logic [BITS_SIZE-1:0] waddr_q, waddr_d;
    logic [BITS_SIZE-1:0] shreg_q, shreg_d;
    logic                 wr_pend_q, wr_pend_d;
    logic                 run_mode_q, run_mode_d;
    logic [DW-1:0]        drain_cnt_q, drain_cnt_d;
    logic [BITS_SIZE-1:0] step_cnt_q, step_cnt_d;
    logic                 overflow_q, overflow_d;
    logic                 rx_ready;
    logic                 step;
    logic                 wr_strobe;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        waddr_d     = waddr_q;
        shreg_d     = shreg_q;
        wr_pend_d   = wr_pend_q;
        run_mode_d  = run_mode_q;
        drain_cnt_d = drain_cnt_q;
        overflow_d  = overflow_q;
        rx_ready    = 1'b0;
        step        = 1'b0;
        wr_strobe   = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (wr_pend_q) begin
                    // Write cycle: shreg/waddr are presented on the IMEM port this cycle.
                    wr_strobe = 1'b1;
                    wr_pend_d = 1'b0;
                    waddr_d   = waddr_q + BITS_SIZE'(4);
                    if (shreg_q == HALT_INSTR) begin
                        state_d = S_READY;
                    end else if (waddr_q == LAST_ADDR) begin
                        overflow_d = 1'b1;
                        state_d    = S_READY;
                    end
                end else begin
                    rx_ready = 1'b1;
                    if (i_rx_valid) begin
                        shreg_d = {shreg_q[BITS_SIZE-9:0], i_rx_data};
                        if (byte_cnt_q == 2'd3) begin
                            byte_cnt_d = 2'd0;
                            wr_pend_d  = 1'b1;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                        end
                    end
                end
            end
            S_READY: begin
                if (i_cmd_run) begin
                    state_d    = S_RUN;
                    run_mode_d = 1'b1;
                end else if (i_cmd_step) begin
                    step = 1'b1;
                end
            end
            S_RUN: begin
                step = 1'b1;
            end
            S_DRAIN: begin
                step = run_mode_q | i_cmd_step;
                if (i_cmd_run) begin
                    run_mode_d = 1'b1;
                end
                if (step) begin
                    drain_cnt_d = drain_cnt_q - DW'(1);
                    if (drain_cnt_q == DW'(1)) begin
                        state_d = S_HALT;
                    end
                end
            end
            default: begin
            end
        endcase

        // A step that fetches the HALT word starts the drain, whichever mode issued it.
        if (step && (state_q == S_READY || state_q == S_RUN) && i_fetch_instr == HALT_INSTR) begin
            state_d     = S_DRAIN;
            drain_cnt_d = DW'(PIPE_DRAIN);
        end

        step_cnt_d = step ? step_cnt_q + BITS_SIZE'(1) : step_cnt_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= S_LOAD;
            byte_cnt_q  <= 2'd0;
            waddr_q     <= '0;
            shreg_q     <= '0;
            wr_pend_q   <= 1'b0;
            run_mode_q  <= 1'b0;
            drain_cnt_q <= '0;
            step_cnt_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            waddr_q     <= waddr_d;
            shreg_q     <= shreg_d;
            wr_pend_q   <= wr_pend_d;
            run_mode_q  <= run_mode_d;
            drain_cnt_q <= drain_cnt_d;
            step_cnt_q  <= step_cnt_d;
            overflow_q  <= overflow_d;
        end
    end

    assign o_rx_ready             = rx_ready;
    assign o_instrucction_address = waddr_q;
    assign o_instruction          = shreg_q;
    assign o_flag_write_intruc    = wr_strobe;
    assign o_step                 = step;
    assign o_load_done            = (state_q != S_LOAD);
    assign o_halted               = (state_q == S_HALT);
    assign o_overflow             = overflow_q;
    assign o_step_count           = step_cnt_q;

endmodule

// File: tb/tb_if_program_loader.sv
// Directed-plus-random bench for if_program_loader; expected writes and step counts come from a word-level model.
module tb_if_program_loader;

    localparam logic [31:0] HALT  = 32'hFFFFFFFF;
    localparam int          PIPE  = 4;
    localparam int          WORDS = 64;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_rx_ready;
    logic        i_cmd_run;
    logic        i_cmd_step;
    logic [31:0] i_fetch_instr;
    logic [31:0] o_instrucction_address;
    logic [31:0] o_instruction;
    logic        o_flag_write_intruc;
    logic        o_step;
    logic        o_load_done;
    logic        o_halted;
    logic        o_overflow;
    logic [31:0] o_step_count;

    if_program_loader #(
        .BITS_SIZE(32), .SIZE_TOTAL(256), .HALT_INSTR(HALT), .PIPE_DRAIN(PIPE)
    ) dut (
        .i_clk                 (i_clk),
        .i_reset               (i_reset),
        .i_rx_data             (i_rx_data),
        .i_rx_valid            (i_rx_valid),
        .o_rx_ready            (o_rx_ready),
        .i_cmd_run             (i_cmd_run),
        .i_cmd_step            (i_cmd_step),
        .i_fetch_instr         (i_fetch_instr),
        .o_instrucction_address(o_instrucction_address),
        .o_instruction         (o_instruction),
        .o_flag_write_intruc   (o_flag_write_intruc),
        .o_step                (o_step),
        .o_load_done           (o_load_done),
        .o_halted              (o_halted),
        .o_overflow            (o_overflow),
        .o_step_count          (o_step_count)
    );

    always #5 i_clk = ~i_clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic        last_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        while (w == HALT) w = $urandom;
        return w;
    endfunction

    // Called at a negedge with inputs applied; samples outputs, then advances one clock.
    task automatic cyc(input int exp_step);
        #1;
        last_rdy = o_rx_ready;
        if (exp_step >= 0) chk("step", 32'(o_step), 32'(exp_step));
        chk("step_write_exclusive", 32'(o_step & o_flag_write_intruc), 0);
        if (o_flag_write_intruc) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                chk("wr_addr", o_instrucction_address, exp_q[0][63:32]);
                chk("wr_data", o_instruction, exp_q[0][31:0]);
                void'(exp_q.pop_front());
            end
        end
        @(negedge i_clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        acc        = 1'b0;
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        for (int n = 0; n < 20 && !acc; n++) begin
            cyc(0);
            acc = last_rdy;
        end
        i_rx_valid = 1'b0;
        if (!acc) chk("rx_accept_timeout", 0, 1);
    endtask

    task automatic load_words(input logic [31:0] w[$]);
        for (int i = 0; i < w.size(); i++) begin
            exp_q.push_back({32'(4 * i), w[i]});
            for (int b = 3; b >= 0; b--) send_byte(w[i][8*b +: 8]);
        end
        cyc(0);
        cyc(0);
        chk("writes_outstanding", 32'(exp_q.size()), 0);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        cyc(-1);
        i_reset = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] prog[$];
        int          k;
        i_reset = 1'b1; i_rx_data = '0; i_rx_valid = 1'b0;
        i_cmd_run = 1'b0; i_cmd_step = 1'b0; i_fetch_instr = '0;
        @(negedge i_clk);
        do_reset();

        #1;
        chk("rst_rx_ready",   32'(o_rx_ready), 1);
        chk("rst_wr",         32'(o_flag_write_intruc), 0);
        chk("rst_step",       32'(o_step), 0);
        chk("rst_load_done",  32'(o_load_done), 0);
        chk("rst_halted",     32'(o_halted), 0);
        chk("rst_overflow",   32'(o_overflow), 0);
        chk("rst_step_count", o_step_count, 0);
        chk("rst_instr",      o_instruction, 0);
        chk("rst_addr",       o_instrucction_address, 0);

        // Partial word discarded by reset; the following word lands at address 0.
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        do_reset();
        prog.delete();
        prog.push_back(32'h20080005);
        k = $urandom_range(0, 3);
        for (int i = 0; i < k; i++) prog.push_back(rand_word());
        prog.push_back(HALT);
        load_words(prog);
        chk("prog_load_done", 32'(o_load_done), 1);
        chk("prog_overflow",  32'(o_overflow), 0);
        i_rx_valid = 1'b1;
        cyc(0);
        cyc(0);
        chk("ready_rx_blocked", 32'(last_rdy), 0);
        i_rx_valid = 1'b0;

        // Three single-step pulses in READY.
        for (int p = 0; p < 3; p++) begin
            i_fetch_instr = rand_word();
            k = $urandom_range(0, 3);
            for (int g = 0; g < k; g++) cyc(0);
            i_cmd_step = 1'b1;
            cyc(1);
            i_cmd_step = 1'b0;
        end
        cyc(0);
        chk("three_steps_count", o_step_count, 3);

        // Continuous run, HALT fetched on the 10th step, then PIPE drain steps.
        i_cmd_run = 1'b1;
        cyc(0);
        i_cmd_run = 1'b0;
        for (int s = 1; s <= 10 + PIPE; s++) begin
            i_fetch_instr = (s == 10) ? HALT : rand_word();
            i_cmd_step    = 1'($urandom);
            cyc(1);
        end
        i_cmd_step    = 1'b0;
        i_fetch_instr = rand_word();
        cyc(0);
        chk("run_halted",     32'(o_halted), 1);
        chk("run_step_count", o_step_count, 3 + 10 + PIPE);
        i_cmd_run  = 1'b1;
        i_cmd_step = 1'b1;
        cyc(0);
        cyc(0);
        i_cmd_run  = 1'b0;
        i_cmd_step = 1'b0;
        chk("halt_sticky",      32'(o_halted), 1);
        chk("halt_count_holds", o_step_count, 3 + 10 + PIPE);

        // Fill the whole memory without HALT.
        do_reset();
        prog.delete();
        for (int i = 0; i < WORDS; i++) prog.push_back(rand_word());
        load_words(prog);
        chk("ovf_flag",      32'(o_overflow), 1);
        chk("ovf_load_done", 32'(o_load_done), 1);
        i_rx_valid = 1'b1;
        i_rx_data  = 8'($urandom);
        cyc(0);
        cyc(0);
        cyc(0);
        chk("ovf_extra_byte_refused", 32'(last_rdy), 0);
        i_rx_valid = 1'b0;

        // Run and step together: run wins and stepping is continuous.
        i_cmd_run  = 1'b1;
        i_cmd_step = 1'b1;
        cyc(0);
        i_cmd_run  = 1'b0;
        for (int s = 0; s < 8; s++) begin
            i_cmd_step    = 1'($urandom);
            i_fetch_instr = rand_word();
            cyc(1);
        end
        i_cmd_step = 1'b0;
        // Reset mid-run: o_step still high while reset is sampled, low afterwards.
        i_reset = 1'b1;
        cyc(1);
        i_reset = 1'b0;
        exp_q.delete();
        cyc(0);
        chk("midrun_rst_count",     o_step_count, 0);
        chk("midrun_rst_load_done", 32'(o_load_done), 0);
        chk("midrun_rst_overflow",  32'(o_overflow), 0);
        chk("midrun_rst_rx_ready",  32'(last_rdy), 1);

        // Single-step drain, later converted to run mode.
        prog.delete();
        prog.push_back(rand_word());
        prog.push_back(HALT);
        load_words(prog);
        k = $urandom_range(1, 4);
        for (int p = 0; p < k; p++) begin
            cyc(0);
            i_fetch_instr = (p == k - 1) ? HALT : rand_word();
            i_cmd_step    = 1'b1;
            cyc(1);
            i_cmd_step    = 1'b0;
        end
        i_fetch_instr = rand_word();
        for (int p = 0; p < 2; p++) begin
            cyc(0);
            i_cmd_step = 1'b1;
            cyc(1);
            i_cmd_step = 1'b0;
        end
        chk("drain_not_halted", 32'(o_halted), 0);
        i_cmd_run = 1'b1;
        cyc(0);
        i_cmd_run = 1'b0;
        cyc(1);
        cyc(1);
        cyc(0);
        chk("drain_halted",     32'(o_halted), 1);
        chk("drain_step_count", o_step_count, 32'(k + PIPE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
